tt_um_jimktrains_vslc_capture: RTL

Input-capture block, the receive-side counterpart of the VSLC dual-period timer. It measures the low-phase and high-phase lengths of an incoming square wave. Both lengths are reported in the same encoding the timer consumes: phase length in cycles minus one. A measured pair fed back into the timer therefore reproduces the waveform. It sits beside the timer in the VSLC peripheral set, e.g. to decode external PWM/tach inputs or to self-check the timer output in loopback.

---
 rtl/tt_um_jimktrains_vslc_pkg.sv | 13 +
 rtl/tt_um_jimktrains_vslc_sync.sv | 25 ++
 rtl/tt_um_jimktrains_vslc_capture.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tt_um_jimktrains_vslc_pkg.sv
// Definitions shared by the VSLC peripheral set: capture FSM encoding and
// the default counter width common to the timer and the capture block.
package tt_um_jimktrains_vslc_pkg;

    localparam int VSLC_WIDTH = 16;

    typedef enum logic [1:0] {
        VSLC_CAP_SYNC = 2'd0,
        VSLC_CAP_LOW  = 2'd1,
        VSLC_CAP_HIGH = 2'd2
    } vslc_cap_state_t;

endpackage

// File: rtl/tt_um_jimktrains_vslc_sync.sv
// N-flop synchronizer for bringing an asynchronous level into the clk domain.
// The output lags the input by exactly STAGES cycles.
module tt_um_jimktrains_vslc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // NOTE: non-blocking assignment lets every stage sample its predecessor's old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= STAGES'({ff, d});
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/tt_um_jimktrains_vslc_capture.sv
// Input capture: measures low/high phase lengths of signal_in, reported as
// length-1 so a captured pair can be fed straight back into the VSLC timer.
module tt_um_jimktrains_vslc_capture
    import tt_um_jimktrains_vslc_pkg::*;
#(
    parameter int WIDTH       = VSLC_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_enabled,
    input  logic             signal_in,
    output logic [WIDTH-1:0] period_a_o,
    output logic [WIDTH-1:0] period_b_o,
    output logic             capture_valid_o,
    output logic             overflow_o,
    output logic [WIDTH-1:0] capture_counter_o
);

    logic s;
    logic s_d;
    logic fall;
    logic rise;

    tt_um_jimktrains_vslc_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (signal_in),
        .q  (s)
    );

    assign fall = s_d & ~s;
    assign rise = ~s_d & s;

    vslc_cap_state_t  state, state_n;
    logic [WIDTH-1:0] counter, counter_n;
    logic [WIDTH-1:0] low_len_r, low_len_n;
    logic             ovf_low_r, ovf_low_n;
    logic             ovf_cur_r, ovf_cur_n;
    logic [WIDTH-1:0] period_a_n, period_b_n;
    logic             valid_n, overflow_n;

    // Saturating increment: a stuck input pins the counter and flags overflow.
    logic             cnt_max;
    logic [WIDTH-1:0] cnt_inc;
    logic             ovf_inc;

    assign cnt_max = (counter == '1);
    assign cnt_inc = cnt_max ? counter : counter + WIDTH'(1);
    assign ovf_inc = ovf_cur_r | cnt_max;

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_n    = state;
        counter_n  = counter;
        low_len_n  = low_len_r;
        ovf_low_n  = ovf_low_r;
        ovf_cur_n  = ovf_cur_r;
        period_a_n = period_a_o;
        period_b_n = period_b_o;
        overflow_n = overflow_o;
        valid_n    = 1'b0;

        if (!capture_enabled) begin
            state_n   = VSLC_CAP_SYNC;
            counter_n = '0;
            ovf_cur_n = 1'b0;
            ovf_low_n = 1'b0;
        end else begin
            unique case (state)
                VSLC_CAP_SYNC: begin
                    counter_n = '0;
                    if (fall) begin
                        ovf_cur_n = 1'b0;
                        state_n   = VSLC_CAP_LOW;
                    end
                end
                VSLC_CAP_LOW: begin
                    if (rise) begin
                        low_len_n = counter;
                        ovf_low_n = ovf_cur_r;
                        counter_n = '0;
                        ovf_cur_n = 1'b0;
                        state_n   = VSLC_CAP_HIGH;
                    end else begin
                        counter_n = cnt_inc;
                        ovf_cur_n = ovf_inc;
                    end
                end
                VSLC_CAP_HIGH: begin
                    // The closing fall publishes the pair and opens the next low phase.
                    if (fall) begin
                        period_a_n = low_len_r;
                        period_b_n = counter;
                        overflow_n = ovf_low_r | ovf_cur_r;
                        valid_n    = 1'b1;
                        counter_n  = '0;
                        ovf_cur_n  = 1'b0;
                        state_n    = VSLC_CAP_LOW;
                    end else begin
                        counter_n = cnt_inc;
                        ovf_cur_n = ovf_inc;
                    end
                end
                default: begin
                    state_n   = VSLC_CAP_SYNC;
                    counter_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= VSLC_CAP_SYNC;
            s_d             <= 1'b0;
            counter         <= '0;
            low_len_r       <= '0;
            ovf_low_r       <= 1'b0;
            ovf_cur_r       <= 1'b0;
            period_a_o      <= '0;
            period_b_o      <= '0;
            overflow_o      <= 1'b0;
            capture_valid_o <= 1'b0;
        end else begin
            state           <= state_n;
            s_d             <= s;
            counter         <= counter_n;
            low_len_r       <= low_len_n;
            ovf_low_r       <= ovf_low_n;
            ovf_cur_r       <= ovf_cur_n;
            period_a_o      <= period_a_n;
            period_b_o      <= period_b_n;
            overflow_o      <= overflow_n;
            capture_valid_o <= valid_n;
        end
    end

    assign capture_counter_o = counter;

endmodule
